bp_update_ctrl: RTL

- Sequences all writes into the global-history branch predictor's PHT.
- After reset, sweeps every PHT entry to the initial counter value. Then buffers branch-resolution records arriving from the M stage and drains them one per granted cycle as saturating-counter read-modify-writes.
- Issues a one-cycle GHR restore command on each accepted mispredict, and keeps branch/mispredict statistics.
- Sits between the M-stage resolution logic and the PHT/GHR storage of the predictor.

---
 rtl/bp_update_ctrl_pkg.sv | 35 +++
 rtl/bp_update_ctrl_fifo.sv | 56 +++++
 rtl/bp_update_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bp_update_ctrl_pkg.sv
// Shared definitions for the branch-predictor PHT update path:
// 2-bit counter encoding, FSM state type and the index/update helpers.
package bp_pkg;

    // Two-bit counter encoding (Gray-ordered so each step flips one bit)
    localparam logic [1:0] SNT = 2'b00;  // strongly not taken
    localparam logic [1:0] WNT = 2'b01;  // weakly not taken
    localparam logic [1:0] WT  = 2'b11;  // weakly taken
    localparam logic [1:0] ST  = 2'b10;  // strongly taken

    localparam int GHR_LENGTH_DEF = 8;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Saturating step along SNT <-> WNT <-> WT <-> ST
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic take);
        logic [1:0] res;
        case (cnt)
            SNT:     res = take ? WNT : SNT;
            WNT:     res = take ? WT  : SNT;
            WT:      res = take ? ST  : WNT;
            default: res = take ? ST  : WT;
        endcase
        return res;
    endfunction

    // Word-aligned PC bits XOR history; caller keeps the low GHR_LENGTH bits
    function automatic logic [31:0] pht_index(input logic [31:0] pc, input logic [31:0] ghr);
        return (pc >> 2) ^ ghr;
    endfunction

endpackage

// File: rtl/bp_update_ctrl_fifo.sv
// Small synchronous show-ahead FIFO holding pending PHT updates.
// Head data is visible combinationally so the PHT read can happen in the
// same cycle as the write-back.
module bp_upd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    // Pointers carry one extra wrap bit to tell full from empty
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr[AW-1:0]];

    // Storage write; contents need no reset since the pointers gate validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_wdata;
        end
    end

    // Pointer update; reset drops every queued entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// PHT write sequencer: initial sweep of every counter, then buffered
// read-modify-write of resolved branches, GHR restore on mispredicts,
// and branch / mispredict statistics.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int         GHR_LENGTH = GHR_LENGTH_DEF,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_CNT   = 2'b11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [31:0]           upd_pc,
    input  logic [GHR_LENGTH-1:0] upd_ghr,
    input  logic                  upd_take,
    input  logic                  upd_pred,
    output logic [GHR_LENGTH-1:0] pht_raddr,
    input  logic [1:0]            pht_rdata,
    input  logic                  pht_wr_gnt,
    output logic                  pht_we,
    output logic [GHR_LENGTH-1:0] pht_waddr,
    output logic [1:0]            pht_wdata,
    output logic                  ghr_restore,
    output logic [GHR_LENGTH-1:0] ghr_restore_val,
    output logic                  init_done,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int FW = GHR_LENGTH + 1;

    state_t                r_state;
    logic [GHR_LENGTH-1:0] r_init_idx;
    logic                  r_init_done;
    logic                  r_restore;
    logic [GHR_LENGTH-1:0] r_restore_val;
    logic [31:0]           r_branch_cnt;
    logic [31:0]           r_miss_cnt;

    logic                  w_in_run;
    logic                  w_accept;
    logic                  w_mispredict;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [GHR_LENGTH-1:0] w_enq_idx;
    logic [FW-1:0]         w_fifo_wdata;
    logic [FW-1:0]         w_fifo_rdata;
    logic [GHR_LENGTH-1:0] w_head_idx;
    logic                  w_head_take;

    // Index is formed at enqueue so the queue stores only index + direction
    assign w_enq_idx    = GHR_LENGTH'(pht_index(upd_pc, 32'(upd_ghr)));
    assign w_fifo_wdata = {upd_take, w_enq_idx};
    assign w_head_take  = w_fifo_rdata[FW-1];
    assign w_head_idx   = w_fifo_rdata[GHR_LENGTH-1:0];

    assign w_in_run     = (r_state == S_RUN);
    assign upd_ready    = w_in_run && !w_full;
    assign w_accept     = upd_valid && upd_ready;
    assign w_mispredict = upd_take ^ upd_pred;
    assign w_pop        = w_in_run && !w_empty && pht_wr_gnt;

    bp_upd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_wdata (w_fifo_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Read side always points at the queue head; don't-care when empty
    assign pht_raddr = w_head_idx;

    // Write port mux: init sweep owns the port, otherwise head RMW when granted
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = w_head_idx;
        pht_wdata = sat_update(pht_rdata, w_head_take);
        if (!w_in_run) begin
            pht_we    = 1'b1;
            pht_waddr = r_init_idx;
            pht_wdata = INIT_CNT;
        end else begin
            pht_we    = w_pop;
        end
    end

    // INIT/RUN sequencer: one init write per cycle, then stay in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_init_idx  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_init_idx <= r_init_idx + 1'b1;
                    if (r_init_idx == '1) begin
                        r_state     <= S_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    // Restore pulse lasts one cycle per accepted mispredict
    always_ff @(posedge clk) begin
        if (rst) begin
            r_restore     <= 1'b0;
            r_restore_val <= '0;
        end else if (w_accept && w_mispredict) begin
            r_restore     <= 1'b1;
            r_restore_val <= {upd_ghr[GHR_LENGTH-2:0], upd_take};
        end else begin
            r_restore     <= 1'b0;
        end
    end

    // Wrapping statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (w_accept) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_mispredict) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign init_done       = r_init_done;
    assign ghr_restore     = r_restore;
    assign ghr_restore_val = r_restore_val;
    assign branch_cnt      = r_branch_cnt;
    assign miss_cnt        = r_miss_cnt;

endmodule
